// File: rtl/gray_server_if.sv
// Bus bundle between the grayscale image server and its two clients:
// the raster-order loader and the LBP engine read port.
// The slave modport is the server side; the master modport is the client side.
interface gray_server_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              restart;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              gray_ready;
  logic              finish;
  logic [31:0]       rd_count;

  modport slave (
    input  ld_valid, ld_data, restart, gray_req, gray_addr, finish,
    output ld_ready, gray_data, gray_ready, rd_count
  );

  modport master (
    output ld_valid, ld_data, restart, gray_req, gray_addr, finish,
    input  ld_ready, gray_data, gray_ready, rd_count
  );
endinterface

// File: rtl/gray_server.sv
// Grayscale image server: loads a raster-order image into an internal
// buffer, then answers zero-latency reads from the LBP engine until it
// signals finish. The stored image can be re-served with restart.
// Optional feature macro: GRAY_RDCNT_EN builds the accepted-read counter;
// without it rd_count is tied to zero.
module gray_server #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic          clk,
  input  logic          reset,
  gray_server_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              ld_ready_q, ld_ready_d;
  logic              gray_ready_q, gray_ready_d;

  // Image buffer; deliberately never cleared so a restart re-serves it.
  logic [DATA_W-1:0] mem [DEPTH];

  logic ld_beat;
  logic rd_acc;

  // The ready flags are registered decodes of the state, so they also
  // serve as the handshake qualifiers.
  assign ld_beat = bus.ld_valid && ld_ready_q;
  assign rd_acc  = bus.gray_req && gray_ready_q;

  // State register, write pointer and registered ready decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      wr_ptr_q     <= '0;
      ld_ready_q   <= 1'b1;
      gray_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      ld_ready_q   <= ld_ready_d;
      gray_ready_q <= gray_ready_d;
    end
  end

  // Next-state logic; the last beat lands at DEPTH-1 and the pointer wraps.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    case (state_q)
      S_LOAD: begin
        if (ld_beat) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = S_SERVE;
          end
        end
      end
      S_SERVE: begin
        if (bus.finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.restart) begin
          state_d = S_SERVE;
        end
      end
      default: begin
        state_d  = S_LOAD;
        wr_ptr_d = '0;
      end
    endcase
  end

  // Output decode of the upcoming state, registered next edge.
  always_comb begin
    ld_ready_d   = (state_d == S_LOAD);
    gray_ready_d = (state_d == S_SERVE);
  end

  // Image write port; reset wins over a coincident load beat.
  always_ff @(posedge clk) begin
    if (!reset && ld_beat) begin
      mem[wr_ptr_q] <= bus.ld_data;
    end
  end

  // Zero-latency read port; idle cycles drive zero.
  always_comb begin
    bus.gray_data = '0;
    if (rd_acc) begin
      bus.gray_data = mem[bus.gray_addr];
    end
  end

  assign bus.ld_ready   = ld_ready_q;
  assign bus.gray_ready = gray_ready_q;

`ifdef GRAY_RDCNT_EN
  logic [31:0] rd_count_q, rd_count_d;

  // Session read counter: cleared on restart, saturating on overflow.
  always_comb begin
    rd_count_d = rd_count_q;
    if (state_q == S_DONE && bus.restart) begin
      rd_count_d = '0;
    end else if (rd_acc && rd_count_q != 32'hFFFF_FFFF) begin
      rd_count_d = rd_count_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign bus.rd_count = rd_count_q;
`else
  assign bus.rd_count = 32'd0;
`endif

endmodule

// File: tb/tb_gray_server.sv
// Self-checking bench for gray_server: directed session steps with
// randomized pixel data and read addresses, checked against an image
// array and an expected read count kept by the bench.
module tb_gray_server;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16384;

  logic clk = 1'b0;
  logic reset;

  gray_server_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gray_server #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] model_mem [DEPTH];
  int unsigned exp_reads;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] cnt_exp();
`ifdef GRAY_RDCNT_EN
    return exp_reads;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int beat;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;

    reset         = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.restart   = 1'b0;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.finish    = 1'b0;
    exp_reads     = 0;
    step();
    step();
    #1;
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_gray_ready", 32'(bus.gray_ready), 32'd0);
    chk("rst_gray_data", 32'(bus.gray_data), 32'd0);
    chk("rst_rd_count", bus.rd_count, 32'd0);
    reset = 1'b0;

    // Load p[i]=i[7:0] with ld_valid held; stray requests must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_valid  = 1'b1;
      bus.ld_data   = 8'(i);
      model_mem[i]  = 8'(i);
      bus.gray_req  = 1'($urandom_range(0, 1));
      bus.gray_addr = 14'($urandom);
      #1;
      if (i % 1024 == 0) begin
        chk("load1_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("load1_gray_ready", 32'(bus.gray_ready), 32'd0);
        chk("load1_gray_data", 32'(bus.gray_data), 32'd0);
        chk("load1_rd_count", bus.rd_count, cnt_exp());
      end
      step();
    end
    bus.ld_valid = 1'b0;
    bus.gray_req = 1'b0;
    chk("load1_done_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("load1_done_gray_ready", 32'(bus.gray_ready), 32'd1);

    // First read: address 300 holds 0x2C.
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd300;
    #1;
    chk("rd300", 32'(bus.gray_data), 32'(model_mem[300]));
    chk("rd300_const", 32'(bus.gray_data), 32'h2C);
    step();
    exp_reads++;

    // Random read traffic until 1000 reads have been accepted.
    n = 1;
    for (int k = 0; k < 20000 && n < 1000; k++) begin
      bus.gray_req  = 1'($urandom_range(0, 1));
      bus.gray_addr = 14'($urandom);
      #1;
      chk("serve_rd", 32'(bus.gray_data),
          bus.gray_req ? 32'(model_mem[bus.gray_addr]) : 32'd0);
      step();
      if (bus.gray_req) begin
        n++;
        exp_reads++;
      end
    end
    chk("serve_count", bus.rd_count, cnt_exp());

    // finish together with a read at address 5.
    bus.finish    = 1'b1;
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd5;
    #1;
    chk("finish_rd5", 32'(bus.gray_data), 32'h05);
    step();
    exp_reads++;
    bus.finish = 1'b0;
    chk("done_gray_ready", 32'(bus.gray_ready), 32'd0);
    chk("done_rd_count", bus.rd_count, cnt_exp());
`ifdef GRAY_RDCNT_EN
    chk("done_rd_count_1001", bus.rd_count, 32'd1001);
`endif

    // Requests in DONE are ignored.
    for (int k = 0; k < 8; k++) begin
      bus.gray_req  = 1'b1;
      bus.gray_addr = 14'($urandom);
      #1;
      chk("done_rd_data", 32'(bus.gray_data), 32'd0);
      step();
    end
    chk("done_rd_count_hold", bus.rd_count, cnt_exp());
    bus.gray_req = 1'b0;

    // Restart re-serves the stored image.
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    exp_reads = 0;
    chk("restart_gray_ready", 32'(bus.gray_ready), 32'd1);
    chk("restart_rd_count", bus.rd_count, cnt_exp());
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd16383;
    #1;
    chk("restart_rd_last", 32'(bus.gray_data), 32'hFF);
    step();
    exp_reads++;
    bus.gray_req = 1'b0;
    chk("restart_count1", bus.rd_count, cnt_exp());

    // Reset while serving.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_reads = 0;
    chk("srv_rst_gray_ready", 32'(bus.gray_ready), 32'd0);
    chk("srv_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("srv_rst_rd_count", bus.rd_count, 32'd0);

    // Partial load of 5000 random beats, then reset discards progress.
    for (int i = 0; i < 5000; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'($urandom);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midload_rst_ld_ready", 32'(bus.ld_ready), 32'd1);

    // Reload with ld_valid every other cycle; last pixel forced to 0xFF.
    beat = 0;
    for (int cyc = 0; cyc < 2 * DEPTH - 1; cyc++) begin
      bus.ld_valid = (cyc % 2 == 0);
      if (bus.ld_valid) begin
        d = (beat == DEPTH - 1) ? 8'hFF : 8'($urandom);
        bus.ld_data = d;
        model_mem[beat] = d;
        beat++;
      end else begin
        bus.ld_data = 8'($urandom);
      end
      bus.gray_req  = 1'($urandom_range(0, 1));
      bus.gray_addr = 14'($urandom);
      #1;
      if (cyc % 997 == 0) begin
        chk("load2_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("load2_gray_ready", 32'(bus.gray_ready), 32'd0);
        chk("load2_gray_data", 32'(bus.gray_data), 32'd0);
        chk("load2_rd_count", bus.rd_count, 32'd0);
      end
      step();
    end
    bus.ld_valid = 1'b0;
    bus.gray_req = 1'b0;
    chk("load2_done_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("load2_done_gray_ready", 32'(bus.gray_ready), 32'd1);

    // Read back every address against the bench image.
    for (int i = 0; i < DEPTH; i++) begin
      a = 14'(i);
      bus.gray_req  = 1'b1;
      bus.gray_addr = a;
      #1;
      chk("readback", 32'(bus.gray_data), 32'(model_mem[i]));
      step();
      exp_reads++;
    end
    bus.gray_req = 1'b0;
    chk("readback_last_ff", 32'(model_mem[DEPTH-1]), 32'hFF);
    chk("readback_rd_count", bus.rd_count, cnt_exp());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_server.md
# gray_server

Host-side grayscale image server for the LBP engine: accepts a 128×128 8-bit image as a raster-order stream, holds it in an internal buffer, then answers the engine's `gray_req`/`gray_addr` reads with `gray_data` while `gray_ready` is high. It is the responder end of the gray-read interface, whose initiator is the `LBP` block. It replaces behavioural image memory so the image path synthesizes. It watches the engine's `finish` to close the session and supports re-serving the same image without reloading.

## Interface
- `DATA_W`, 8, pixel width
- `ADDR_W`, 14, address width
- `DEPTH`, 16384, pixel count (must equal 2^`ADDR_W`)

- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `ld_valid`  in  1  load pixel present
- `ld_data`  in  `DATA_W`  load pixel, raster order, address 0 first
- `ld_ready`  out  1  block accepts load pixels
- `restart`  in  1  re-serve the stored image (honoured in DONE only)
- `gray_req`  in  1  read request from LBP engine
- `gray_addr`  in  `ADDR_W`  read address
- `gray_data`  out  `DATA_W`  read data
- `gray_ready`  out  1  image available for reads
- `finish`  in  1  engine done
- `rd_count`  out  32  accepted reads this session (see Configuration)

## Operation
- States: LOAD → SERVE → DONE. DONE → SERVE on `restart`. Reset from any state → LOAD.
- LOAD:
  - `ld_ready`=1.
  - A beat occurs when `ld_valid`&&`ld_ready`. It writes `ld_data` to `mem[wr_ptr]` and increments `wr_ptr`.
  - The beat at `wr_ptr`=`DEPTH`-1 wraps `wr_ptr` to 0 and moves to SERVE.
  - `finish`, `restart`, `gray_req` are ignored.
- SERVE:
  - `gray_ready`=1, `ld_ready`=0.
  - A read is accepted when `gray_req`=1. `gray_data`=`mem[gray_addr]` combinationally in the same cycle.
  - Each accepted read increments `rd_count` (saturates at 2^32-1).
  - `finish`=1 moves to DONE. A read in the same cycle is still served and counted.
- DONE:
  - `gray_ready`=0. `gray_req` is ignored; `rd_count` holds.
  - `restart`=1 moves to SERVE and clears `rd_count` to 0.
- `gray_data`=0 whenever no read is accepted.
- Memory contents are never cleared by reset. A reload after reset overwrites them.
- Only the full address width is used, so no out-of-range address can occur.

## Timing
- Reset values: state=LOAD, `wr_ptr`=0, `ld_ready`=1, `gray_ready`=0, `gray_data`=0, `rd_count`=0.
- `ld_ready` and `gray_ready` are registered state decodes.
- Load:
  - The final pixel is written on edge N. `gray_ready`=1 from cycle N+1; `ld_ready`=0 from N+1.
  - Full load takes `DEPTH` beats minimum; `ld_valid` gaps stall without penalty.
- Read latency is 0 cycles: data is valid in the request cycle and is sampled by the engine at the next rising edge.
- `finish` sampled high at edge F: `gray_ready`=0 from cycle F+1.
- `restart` sampled high at edge R in DONE: `gray_ready`=1 from R+1; `rd_count`=0 at R+1.
- `reset` sampled high overrides all other inputs that edge. Mid-load reset discards progress (`wr_ptr`=0). Mid-serve reset drops `gray_ready` the next cycle.

## Configuration
- `GRAY_RDCNT_EN` defined: the 32-bit `rd_count` register and its increment/clear/saturate logic are built.
- `GRAY_RDCNT_EN` undefined: `rd_count` is tied to 0 and no counter logic exists. All other behaviour is identical.

## Test plan
- Reset, then stream pixels `p[i]=i[7:0]` with `ld_valid` held 1 → `ld_ready` falls exactly 16384 cycles later; `gray_ready`=1 the next cycle; `gray_req`=1 with `gray_addr`=300 gives `gray_data`=0x2C in the same cycle.
- Load with `ld_valid` toggling every other cycle → load completes after 32767 cycles; `mem[16383]`=0xFF; no pixel is skipped or duplicated (read back all 16384 addresses).
- In SERVE, issue 1000 reads, then raise `finish` together with a read at address 5 → `gray_data`=0x05 that cycle; `rd_count`=1001; `gray_ready`=0 the next cycle; later `gray_req` leaves `rd_count` at 1001 and `gray_data`=0.
- In DONE, pulse `restart` → `gray_ready`=1 the next cycle; `rd_count`=0; reading address 16383 returns 0xFF with no reload.
- Assert `reset` after 5000 load beats, then load a full image of constant 0xA5 → all addresses read 0xA5; `gray_ready` stays 0 until the 16384th new beat.
- `gray_req`=1 during LOAD → `gray_data`=0 and `rd_count` is unchanged. With `GRAY_RDCNT_EN` undefined, `rd_count`=0 throughout every scenario above.
